ysyx_23060025_xbar_rd: RTL
==========================

Name: ysyx_23060025_xbar_rd

Overview:
Read-only address-decoding crossbar between the LSU read master and the read slaves: the CLINT and the main memory AXI read port. It accepts one read request at a time, decodes the latched address, and forwards it to the selected slave. The slave's data response is muxed back to the master. Unmapped addresses are answered locally with DECERR.

Parameters:
ADDR_LEN, 32, address width.
DATA_LEN, 32, data width.
CLINT_BASE, 32'h0200_0000, CLINT region base.
CLINT_SIZE, 32'h0001_0000, CLINT region size in bytes.
MEM_BASE, 32'h8000_0000, memory region base.
MEM_SIZE, 32'h0800_0000, memory region size in bytes.
TIMEOUT_CYCLES, 16, address-phase timeout limit; used only with XBAR_TIMEOUT_EN.

Ports:
clock  in  1  system clock.
rstn  in  1  reset; asynchronous, active-low.
m_addr_r_addr_i  in  ADDR_LEN  master read address.
m_addr_r_valid_i  in  1  master address valid.
m_addr_r_ready_o  out  1  xbar ready to accept an address.
m_r_data_o  out  DATA_LEN  read data to master.
m_r_resp_o  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR.
m_r_valid_o  out  1  read data valid.
m_r_last_o  out  1  last beat; always 1 while m_r_valid_o is high.
m_r_ready_i  in  1  master accepts data.
clint_addr_r_addr_o / clint_addr_r_valid_o / clint_addr_r_ready_i  out/out/in  ADDR_LEN/1/1  CLINT address channel.
clint_r_data_i / clint_r_resp_i / clint_r_valid_i / clint_r_last_i / clint_r_ready_o  in/in/in/in/out  DATA_LEN/2/1/1/1  CLINT data channel.
mem_addr_r_addr_o / mem_addr_r_valid_o / mem_addr_r_ready_i  out/out/in  ADDR_LEN/1/1  memory address channel.
mem_r_data_i / mem_r_resp_i / mem_r_valid_i / mem_r_last_i / mem_r_ready_o  in/in/in/in/out  DATA_LEN/2/1/1/1  memory data channel.

Behaviour:
- Clock is clock. Reset is asynchronous, active-low, on rstn.
- Reset state: S_IDLE; latched address 0; sel 0.
- While reset is asserted, every output valid and ready is 0, including m_addr_r_ready_o. All data and resp outputs are 0.
- FSM states: S_IDLE, S_ADDR, S_DATA, S_ERR. Only one transaction is outstanding; no pipelining.
- S_IDLE:
  - m_addr_r_ready_o = 1.
  - On m_addr_r_valid_i & ready, latch the address and decode it into sel.
  - sel = CLINT if CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE; sel = MEM if inside the memory region; otherwise ERR.
  - Range compares use unsigned ADDR_LEN+1-bit arithmetic, so the base+size computation does not wrap.
  - Next state is S_ADDR for CLINT or MEM, S_ERR for an unmapped address.
- S_ADDR:
  - The selected slave's addr_r_valid_o = 1 and its addr_r_addr_o = the latched address. The unselected slave sees valid 0.
  - On the selected slave's addr_r_ready_i, go to S_DATA.
  - A slave ready in the same cycle as the request is accepted: one cycle in S_ADDR minimum.
  - Minimum latency: request accept to slave valid, 1 cycle.
- S_DATA:
  - Combinational mux: m_r_data_o, m_r_resp_o, m_r_valid_o and m_r_last_o come from the selected slave.
  - The selected slave's r_ready_o = m_r_ready_i. The unselected slave's r_ready_o = 0.
  - On selected r_valid & m_r_ready_i, go to S_IDLE.
  - A slave r_valid from the unselected slave is ignored.
- S_ERR:
  - m_r_valid_o = 1, m_r_resp_o = 2'b11, m_r_data_o = 0, m_r_last_o = 1.
  - On m_r_ready_i, go to S_IDLE. No slave is touched.
- m_addr_r_ready_o is 0 outside S_IDLE. A new request is accepted no earlier than the cycle after the data handshake.
- A master that holds m_r_ready_i low keeps the state and the muxed outputs stable.
- Reset asserted mid-transaction: return to S_IDLE immediately. No response is issued; any slave side effects are the slave's concern.

Optional Feature:
- Macro: XBAR_TIMEOUT_EN.
- Defined:
  - A clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to S_ADDR and increments each cycle in S_ADDR.
  - If it reaches TIMEOUT_CYCLES without a slave addr_r_ready_i, the xbar drops the slave addr_r_valid_o.
  - It then enters S_ERR with m_r_resp_o = 2'b10 (SLVERR).
  - Safe because the slave never accepted the address.
- Undefined: the counter is absent and S_ADDR waits indefinitely.

Test Plan:
- Read 0x0200_BFF8, CLINT ready after 2 cycles, returns 0x1234_5678 OKAY -> master gets data 0x1234_5678, resp 00, last 1; mem channel valids stay 0.
- Read 0x8000_0004, mem returns 0xDEAD_BEEF -> master gets 0xDEAD_BEEF; clint_addr_r_valid_o never asserted.
- Read 0x1000_0000 -> S_ERR: m_r_valid_o 1 the cycle after accept, resp 11, data 0; no slave valid asserted.
- Mem data valid with m_r_ready_i held low 5 cycles -> outputs stable, mem_r_ready_o 0; the handshake on cycle 6 returns to S_IDLE, and m_addr_r_ready_o is 1 the next cycle.
- rstn pulsed low while in S_DATA -> all outputs 0 asynchronously; after release, a fresh read to 0x8000_0000 completes normally.
- With XBAR_TIMEOUT_EN and CLINT addr_r_ready_i tied 0 -> clint_addr_r_valid_o high exactly 16 cycles, then master gets resp 10.

Source files
------------

// File: rtl/ysyx_23060025_xbar_rd.sv
// Read crossbar: LSU master -> CLINT / main memory, DECERR for unmapped.
// Optional XBAR_TIMEOUT_EN aborts a stalled address phase with SLVERR.
module ysyx_23060025_xbar_rd #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_LEN-1:0] CLINT_SIZE = 32'h0001_0000,
  parameter logic [ADDR_LEN-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [ADDR_LEN-1:0] MEM_SIZE = 32'h0800_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] m_addr_r_addr_i,
  input  logic                m_addr_r_valid_i,
  output logic                m_addr_r_ready_o,
  output logic [DATA_LEN-1:0] m_r_data_o,
  output logic [1:0]          m_r_resp_o,
  output logic                m_r_valid_o,
  output logic                m_r_last_o,
  input  logic                m_r_ready_i,
  output logic [ADDR_LEN-1:0] clint_addr_r_addr_o,
  output logic                clint_addr_r_valid_o,
  input  logic                clint_addr_r_ready_i,
  input  logic [DATA_LEN-1:0] clint_r_data_i,
  input  logic [1:0]          clint_r_resp_i,
  input  logic                clint_r_valid_i,
  input  logic                clint_r_last_i,
  output logic                clint_r_ready_o,
  output logic [ADDR_LEN-1:0] mem_addr_r_addr_o,
  output logic                mem_addr_r_valid_o,
  input  logic                mem_addr_r_ready_i,
  input  logic [DATA_LEN-1:0] mem_r_data_i,
  input  logic [1:0]          mem_r_resp_i,
  input  logic                mem_r_valid_i,
  input  logic                mem_r_last_i,
  output logic                mem_r_ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_CLINT, SEL_MEM, SEL_ERR} sel_t;

  // One extra bit keeps base+size from wrapping at the top of the map.
  localparam logic [ADDR_LEN:0] CLINT_LO = {1'b0, CLINT_BASE};
  localparam logic [ADDR_LEN:0] CLINT_HI = CLINT_LO + {1'b0, CLINT_SIZE};
  localparam logic [ADDR_LEN:0] MEM_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_LEN:0] MEM_HI = MEM_LO + {1'b0, MEM_SIZE};

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_t state_q, state_d;
  sel_t sel_q, sel_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;

`ifdef XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic [ADDR_LEN:0] a_ext;
  logic hit_clint, hit_mem;
  logic is_clint, is_mem;
  logic s_ar_ready, s_r_valid, s_r_last;
  logic [DATA_LEN-1:0] s_r_data;
  logic [1:0] s_r_resp;

  assign a_ext = {1'b0, m_addr_r_addr_i};
  assign hit_clint = (a_ext >= CLINT_LO) && (a_ext < CLINT_HI);
  assign hit_mem = (a_ext >= MEM_LO) && (a_ext < MEM_HI);

  assign is_clint = sel_q == SEL_CLINT;
  assign is_mem = sel_q == SEL_MEM;

  assign s_ar_ready = is_clint ? clint_addr_r_ready_i : mem_addr_r_ready_i;
  assign s_r_valid = is_clint ? clint_r_valid_i : mem_r_valid_i;
  assign s_r_last = is_clint ? clint_r_last_i : mem_r_last_i;
  assign s_r_data = is_clint ? clint_r_data_i : mem_r_data_i;
  assign s_r_resp = is_clint ? clint_r_resp_i : mem_r_resp_i;

  // Gated by rstn so the master never sees ready while held in reset.
  assign m_addr_r_ready_o = rstn && (state_q == S_IDLE);

  assign clint_addr_r_addr_o = addr_q;
  assign mem_addr_r_addr_o = addr_q;
  assign clint_addr_r_valid_o = (state_q == S_ADDR) && is_clint;
  assign mem_addr_r_valid_o = (state_q == S_ADDR) && is_mem;
  assign clint_r_ready_o = (state_q == S_DATA) && is_clint && m_r_ready_i;
  assign mem_r_ready_o = (state_q == S_DATA) && is_mem && m_r_ready_i;

  always_comb begin
    m_r_valid_o = 1'b0;
    m_r_data_o = '0;
    m_r_resp_o = 2'b00;
    m_r_last_o = 1'b0;
    unique case (state_q)
      S_DATA: begin
        m_r_valid_o = s_r_valid;
        m_r_data_o = s_r_data;
        m_r_resp_o = s_r_resp;
        m_r_last_o = s_r_last;
      end
      S_ERR: begin
        m_r_valid_o = 1'b1;
        m_r_resp_o = (sel_q == SEL_ERR) ? 2'b11 : 2'b10;
        m_r_last_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    addr_d = addr_q;
`ifdef XBAR_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (m_addr_r_valid_i) begin
          addr_d = m_addr_r_addr_i;
          unique case (1'b1)
            hit_clint: sel_d = SEL_CLINT;
            hit_mem: sel_d = SEL_MEM;
            default: sel_d = SEL_ERR;
          endcase
          state_d = (hit_clint || hit_mem) ? S_ADDR : S_ERR;
`ifdef XBAR_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_ADDR: begin
        if (s_ar_ready) begin
          state_d = S_DATA;
`ifdef XBAR_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_DATA: begin
        if (s_r_valid && m_r_ready_i) state_d = S_IDLE;
      end
      S_ERR: begin
        if (m_r_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sel_q <= SEL_NONE;
      addr_q <= '0;
`ifdef XBAR_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
`ifdef XBAR_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule
